// File: rtl/l0_instr_cache_sa.sv
// Set-associative L0 instruction cache with a zero-cycle hit path and a single
// outstanding line fill toward the L1I. Supports flush with response drain.
module l0_instr_cache_sa #(
  parameter int unsigned SETS            = 8,
  parameter int unsigned LINE_SIZE_BYTES = 64,
  parameter int unsigned A               = 2,
  parameter int unsigned PC_SIZE         = 64,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         flush_in,
  input  logic                         req_valid_in,
  input  logic [PC_SIZE-1:0]           req_pc_in,
  output logic                         hit_out,
  output logic [LINE_SIZE_BYTES*8-1:0] line_out,
  output logic                         miss_pending_out,
  output logic                         l1_req_valid_out,
  output logic [PC_SIZE-1:0]           l1_req_pc_out,
  input  logic                         l1_req_ready_in,
  input  logic                         l1_resp_valid_in,
  input  logic [LINE_SIZE_BYTES*8-1:0] l1_resp_data_in,
  output logic [CNT_W-1:0]             hit_count_out,
  output logic [CNT_W-1:0]             miss_count_out
);

  localparam int unsigned OffW  = $clog2(LINE_SIZE_BYTES);
  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned TagW  = PC_SIZE - OffW - IdxW;
  localparam int unsigned WayW  = (A > 1) ? $clog2(A) : 1;
  localparam int unsigned LineW = LINE_SIZE_BYTES * 8;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

  state_e             state_q, state_d;
  logic [PC_SIZE-1:0] miss_pc_q, miss_pc_d;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;
  logic [A-1:0]       valid_q [SETS];
  logic [WayW-1:0]    rr_q    [SETS];
  logic [TagW-1:0]    tag_q   [SETS][A];
  logic [LineW-1:0]   data_q  [SETS][A];

  logic [IdxW-1:0]  req_idx, fill_idx;
  logic [TagW-1:0]  req_tag, fill_tag;
  logic             any_match, hit;
  logic [LineW-1:0] match_line;
  logic [WayW-1:0]  victim;
  logic             found_invalid, all_valid;
  logic             launch, fill_en;

  assign req_idx  = req_pc_in[OffW +: IdxW];
  assign req_tag  = req_pc_in[PC_SIZE-1 -: TagW];
  assign fill_idx = miss_pc_q[OffW +: IdxW];
  assign fill_tag = miss_pc_q[PC_SIZE-1 -: TagW];

  // Tags are unique within a set, so OR-ing the matching ways selects one line.
  always_comb begin
    any_match  = 1'b0;
    match_line = '0;
    for (int unsigned w = 0; w < A; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        any_match  = 1'b1;
        match_line = match_line | data_q[req_idx][w];
      end
    end
  end

  assign hit      = req_valid_in & any_match & ~flush_in;
  assign hit_out  = hit;
  assign line_out = hit ? match_line : '0;

  always_comb begin
    victim        = rr_q[fill_idx];
    found_invalid = 1'b0;
    all_valid     = &valid_q[fill_idx];
    for (int unsigned w = 0; w < A; w++) begin
      if (!found_invalid && !valid_q[fill_idx][w]) begin
        victim        = WayW'(w);
        found_invalid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    miss_pc_d = miss_pc_q;
    launch    = 1'b0;
    fill_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_in && !hit && !flush_in) begin
          launch    = 1'b1;
          miss_pc_d = req_pc_in & ~PC_SIZE'(LINE_SIZE_BYTES - 1);
          state_d   = StReq;
        end
      end
      StReq: begin
        if (flush_in)             state_d = StIdle;
        else if (l1_req_ready_in) state_d = StWait;
      end
      StWait: begin
        if (flush_in) begin
          // A response landing with the flush is dropped; nothing left to drain.
          state_d = l1_resp_valid_in ? StIdle : StDrain;
        end else if (l1_resp_valid_in) begin
          fill_en = 1'b1;
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (l1_resp_valid_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      miss_pc_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      miss_pc_q <= miss_pc_d;
      if (hit && (hit_cnt_q != '1))     hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      if (launch && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      if (flush_in) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
      end else if (fill_en) begin
        valid_q[fill_idx][victim] <= 1'b1;
        if (all_valid) begin
          rr_q[fill_idx] <= (rr_q[fill_idx] == WayW'(A - 1)) ? '0 : rr_q[fill_idx] + WayW'(1);
        end
      end
    end
  end

  // Tag and data storage need no reset; the valid bits qualify them.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_q[fill_idx][victim]  <= fill_tag;
      data_q[fill_idx][victim] <= l1_resp_data_in;
    end
  end

  assign miss_pending_out = (state_q != StIdle);
  assign l1_req_valid_out = (state_q == StReq);
  assign l1_req_pc_out    = miss_pc_q;
  assign hit_count_out    = hit_cnt_q;
  assign miss_count_out   = miss_cnt_q;

endmodule

// File: tb/tb_l0_instr_cache_sa.sv
// Directed bench for l0_instr_cache_sa: lookup vector table plus hand-written
// sequences for fills, replacement, stalls, flush/drain, reset and saturation.
module tb_l0_instr_cache_sa;

  logic         clk, rst, flush, req_valid, l1_req_ready, l1_resp_valid;
  logic [63:0]  req_pc, l1_req_pc, l1_req_pc_s;
  logic [511:0] line, line_s, l1_resp_data;
  logic         hit, hit_s, miss_pending, miss_pending_s, l1_req_valid, l1_req_valid_s;
  logic [31:0]  hit_cnt, miss_cnt;
  logic [3:0]   hit_cnt_s, miss_cnt_s;

  int checks = 0;
  int passes = 0;
  int hit_exp = 0;
  int miss_exp = 0;

  l0_instr_cache_sa dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .req_valid_in(req_valid),
    .req_pc_in(req_pc), .hit_out(hit), .line_out(line), .miss_pending_out(miss_pending),
    .l1_req_valid_out(l1_req_valid), .l1_req_pc_out(l1_req_pc),
    .l1_req_ready_in(l1_req_ready), .l1_resp_valid_in(l1_resp_valid),
    .l1_resp_data_in(l1_resp_data), .hit_count_out(hit_cnt), .miss_count_out(miss_cnt)
  );

  l0_instr_cache_sa #(.CNT_W(4)) dut_sat (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .req_valid_in(req_valid),
    .req_pc_in(req_pc), .hit_out(hit_s), .line_out(line_s),
    .miss_pending_out(miss_pending_s), .l1_req_valid_out(l1_req_valid_s),
    .l1_req_pc_out(l1_req_pc_s), .l1_req_ready_in(l1_req_ready),
    .l1_resp_valid_in(l1_resp_valid), .l1_resp_data_in(l1_resp_data),
    .hit_count_out(hit_cnt_s), .miss_count_out(miss_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           ph;
    logic [63:0]  pc;
    logic         exp_hit;
    logic [511:0] exp_line;
  } vec_t;

  vec_t vt [13];

  function automatic logic [511:0] dat(input logic [63:0] pc);
    return {8{pc ^ 64'h0123_4567_89ab_cdef}};
  endfunction

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passes++;
  endtask

  task automatic probe(input string name, input logic [63:0] pc, input logic eh,
                       input logic [511:0] el);
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = pc;
    #1;
    chk({name, ".hit"}, 512'(hit), 512'(eh));
    chk({name, ".line"}, line, el);
    req_valid = 1'b0;
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < 13; i++)
      if (vt[i].ph == p) probe($sformatf("vec%0d", i), vt[i].pc, vt[i].exp_hit, vt[i].exp_line);
  endtask

  task automatic fill(input logic [63:0] pc);
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = pc;
    @(negedge clk);
    req_valid    = 1'b0;
    l1_req_ready = 1'b1;
    @(negedge clk);
    l1_req_ready  = 1'b0;
    l1_resp_valid = 1'b1;
    l1_resp_data  = dat(pc);
    @(negedge clk);
    l1_resp_valid = 1'b0;
    miss_exp++;
  endtask

  initial begin
    vt[0]  = '{0, 64'h0000, 1'b0, '0};
    vt[1]  = '{0, 64'h0204, 1'b1, dat(64'h0200)};
    vt[2]  = '{0, 64'h0408, 1'b1, dat(64'h0400)};
    vt[3]  = '{0, 64'h1000, 1'b0, '0};
    vt[4]  = '{1, 64'h0010, 1'b1, dat(64'h0000)};
    vt[5]  = '{1, 64'h0200, 1'b0, '0};
    vt[6]  = '{1, 64'h0400, 1'b1, dat(64'h0400)};
    vt[7]  = '{2, 64'h4000, 1'b0, '0};
    vt[8]  = '{2, 64'h2000, 1'b0, '0};
    vt[9]  = '{2, 64'h0000, 1'b0, '0};
    vt[10] = '{2, 64'h1040, 1'b0, '0};
    vt[11] = '{3, 64'h5000, 1'b0, '0};
    vt[12] = '{3, 64'h0400, 1'b0, '0};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pc = '0;
    l1_req_ready = 1'b0; l1_resp_valid = 1'b0; l1_resp_data = '0;
    #12;
    chk("rst.hit", 512'(hit), 512'(0));
    chk("rst.line", line, '0);
    chk("rst.pending", 512'(miss_pending), 512'(0));
    chk("rst.l1v", 512'(l1_req_valid), 512'(0));
    chk("rst.l1pc", 512'(l1_req_pc), 512'(0));
    chk("rst.cnts", 512'({hit_cnt, miss_cnt}), 512'(0));
    @(negedge clk);
    rst = 1'b0;

    // First miss and fill, then a hit within the same line.
    @(negedge clk);
    req_valid = 1'b1; req_pc = 64'h1000;
    #1 chk("t1.miss", 512'(hit), 512'(0));
    @(negedge clk);
    req_valid = 1'b0;
    miss_exp++;
    chk("t1.l1v", 512'(l1_req_valid), 512'(1));
    chk("t1.l1pc", 512'(l1_req_pc), 512'(64'h1000));
    chk("t1.mcnt", 512'(miss_cnt), 512'(miss_exp));
    chk("t1.pend", 512'(miss_pending), 512'(1));
    l1_req_ready = 1'b1;
    @(negedge clk);
    l1_req_ready = 1'b0;
    chk("t1.wait_l1v", 512'(l1_req_valid), 512'(0));
    l1_resp_valid = 1'b1; l1_resp_data = dat(64'h1000);
    @(negedge clk);
    l1_resp_valid = 1'b0;
    chk("t1.idle", 512'(miss_pending), 512'(0));
    req_valid = 1'b1; req_pc = 64'h1004;
    #1 chk("t1.hit", 512'(hit), 512'(1));
    chk("t1.line", line, dat(64'h1000));
    hit_exp++;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t1.hcnt", 512'(hit_cnt), 512'(hit_exp));

    // Flush cycle forces hit low, then the line is gone.
    flush = 1'b1; req_valid = 1'b1; req_pc = 64'h1004;
    #1 chk("fl.hit_forced", 512'(hit), 512'(0));
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    probe("fl.after", 64'h1004, 1'b0, '0);

    // Replacement within set 0.
    fill(64'h0000);
    fill(64'h0200);
    fill(64'h0400);
    run_phase(0);
    fill(64'h0000);
    run_phase(1);
    chk("repl.mcnt", 512'(miss_cnt), 512'(miss_exp));

    // Held request with hit-under-miss and an uncounted miss.
    fill(64'h1040);
    @(negedge clk);
    req_valid = 1'b1; req_pc = 64'h2000;
    @(negedge clk);
    req_valid = 1'b0;
    miss_exp++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("stall%0d.l1v", i), 512'(l1_req_valid), 512'(1));
      chk($sformatf("stall%0d.l1pc", i), 512'(l1_req_pc), 512'(64'h2000));
      if (i == 1) begin
        req_valid = 1'b1; req_pc = 64'h1044;
        #1 chk("stall.hum", 512'(hit), 512'(1));
        chk("stall.humline", line, dat(64'h1040));
        hit_exp++;
      end else if (i == 2) begin
        req_valid = 1'b1; req_pc = 64'h3000;
        #1 chk("stall.miss", 512'(hit), 512'(0));
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("stall.mcnt", 512'(miss_cnt), 512'(miss_exp));
    chk("stall.hcnt", 512'(hit_cnt), 512'(hit_exp));
    l1_req_ready = 1'b1;
    @(negedge clk);
    l1_req_ready = 1'b0; l1_resp_valid = 1'b1; l1_resp_data = dat(64'h2000);
    @(negedge clk);
    l1_resp_valid = 1'b0;
    probe("stall.filled", 64'h2000, 1'b1, dat(64'h2000));

    // Flush in REQ withdraws the request.
    @(negedge clk);
    req_valid = 1'b1; req_pc = 64'h3000;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    miss_exp++;
    @(negedge clk);
    flush = 1'b0;
    chk("flreq.l1v", 512'(l1_req_valid), 512'(0));
    chk("flreq.pend", 512'(miss_pending), 512'(0));

    // Flush in WAIT drains the next response.
    @(negedge clk);
    req_valid = 1'b1; req_pc = 64'h4000;
    @(negedge clk);
    req_valid = 1'b0; l1_req_ready = 1'b1;
    miss_exp++;
    @(negedge clk);
    l1_req_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain.pend", 512'(miss_pending), 512'(1));
    req_valid = 1'b1; req_pc = 64'h4000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("drain.nolaunch", 512'(l1_req_valid), 512'(0));
    chk("drain.mcnt", 512'(miss_cnt), 512'(miss_exp));
    l1_resp_valid = 1'b1; l1_resp_data = dat(64'h4000);
    @(negedge clk);
    l1_resp_valid = 1'b0;
    chk("drain.idle", 512'(miss_pending), 512'(0));
    run_phase(2);
    fill(64'h4000);
    probe("drain.refill", 64'h4000, 1'b1, dat(64'h4000));
    chk("drain.mcnt2", 512'(miss_cnt), 512'(miss_exp));

    // Flush coinciding with the response in WAIT returns straight to IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_pc = 64'h7000;
    @(negedge clk);
    req_valid = 1'b0; l1_req_ready = 1'b1;
    @(negedge clk);
    l1_req_ready = 1'b0; flush = 1'b1; l1_resp_valid = 1'b1; l1_resp_data = dat(64'h7000);
    @(negedge clk);
    flush = 1'b0; l1_resp_valid = 1'b0;
    chk("flresp.idle", 512'(miss_pending), 512'(0));
    probe("flresp.miss", 64'h7000, 1'b0, '0);

    // Asynchronous reset in the middle of a request.
    @(negedge clk);
    req_valid = 1'b1; req_pc = 64'h5000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid.l1v_before", 512'(l1_req_valid), 512'(1));
    #2 rst = 1'b1;
    #1;
    chk("rstmid.l1v", 512'(l1_req_valid), 512'(0));
    chk("rstmid.l1pc", 512'(l1_req_pc), 512'(0));
    chk("rstmid.pend", 512'(miss_pending), 512'(0));
    chk("rstmid.cnts", 512'({hit_cnt, miss_cnt}), 512'(0));
    @(negedge clk);
    rst = 1'b0; hit_exp = 0; miss_exp = 0;
    l1_resp_valid = 1'b1; l1_resp_data = dat(64'h5000);
    @(negedge clk);
    l1_resp_valid = 1'b0;
    chk("rstmid.idle", 512'(miss_pending), 512'(0));
    run_phase(3);

    // Saturating hit counter on the narrow-counter instance.
    fill(64'h6000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_pc = 64'h6000;
      hit_exp++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("sat.hcnt32", 512'(hit_cnt), 512'(hit_exp));
    chk("sat.hcnt4", 512'(hit_cnt_s), 512'(4'hF));
    chk("sat.mcnt4", 512'(miss_cnt_s), 512'(miss_exp));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
